// File: rtl/sysid_reader.sv
// Avalon-MM read master that fetches the system-ID and timestamp words and
// reports whether they match the build-time expected values.
`timescale 1ns/1ps
module sysid_reader #(
    parameter logic [31:0] EXPECTED_ID = 32'd0,
    parameter logic [31:0] EXPECTED_TS = 32'd1637742172,
    parameter logic [15:0] TIMEOUT_CYC = 16'd255,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID_CMD,
        S_ID_WAIT,
        S_TS_CMD,
        S_TS_WAIT,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        auto_pend;
    logic [15:0] tmo_cnt;

    logic        in_cmd;
    logic        in_wait;
    logic        in_id;
    logic        in_ts;
    logic        accepted;
    logic        resp;
    logic        expired;
    logic        launch;
    logic        cmd_entry;

    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return a == b;
    endfunction

    // A response is only meaningful once our command has been accepted,
    // which filters out stale data left over from an aborted check.
    always_comb begin
        in_cmd    = (state == S_ID_CMD) || (state == S_TS_CMD);
        in_wait   = (state == S_ID_WAIT) || (state == S_TS_WAIT);
        in_id     = (state == S_ID_CMD) || (state == S_ID_WAIT);
        in_ts     = (state == S_TS_CMD) || (state == S_TS_WAIT);
        accepted  = in_cmd && !avm_waitrequest;
        resp      = (accepted || in_wait) && avm_readdatavalid;
        expired   = (in_cmd || in_wait) && !resp
                    && (tmo_cnt == (TIMEOUT_CYC - 16'd1));
        launch    = ((state == S_IDLE) || (state == S_DONE)) && (start || auto_pend);
        cmd_entry = launch || (in_id && resp);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (launch) state_nxt = S_ID_CMD;
            end
            S_ID_CMD: begin
                if (resp)          state_nxt = S_TS_CMD;
                else if (expired)  state_nxt = S_DONE;
                else if (accepted) state_nxt = S_ID_WAIT;
            end
            S_ID_WAIT: begin
                if (resp)          state_nxt = S_TS_CMD;
                else if (expired)  state_nxt = S_DONE;
            end
            S_TS_CMD: begin
                if (resp || expired) state_nxt = S_DONE;
                else if (accepted)   state_nxt = S_TS_WAIT;
            end
            S_TS_WAIT: begin
                if (resp || expired) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus strobes decode straight from the state so reset drops them at once.
    always_comb begin
        avm_read    = in_cmd;
        avm_address = in_ts;
        busy        = in_cmd || in_wait;
        done        = (state == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            auto_pend <= AUTO_START;
        end else if (launch) begin
            auto_pend <= 1'b0;
        end
    end

    // Per-read budget covering both the command and the response phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt <= 16'd0;
        end else if (cmd_entry) begin
            tmo_cnt <= 16'd0;
        end else if (in_cmd || in_wait) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_value <= 32'd0;
            ts_value <= 32'd0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
        end else if (launch) begin
            id_value <= 32'd0;
            ts_value <= 32'd0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (resp && in_id) begin
                id_value <= avm_readdata;
                id_ok    <= word_match(avm_readdata, EXPECTED_ID);
            end
            if (resp && in_ts) begin
                ts_value <= avm_readdata;
                ts_ok    <= word_match(avm_readdata, EXPECTED_TS);
            end
            if (expired) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sysid_reader.sv
// Directed bench for sysid_reader: a configurable Avalon slave model drives the
// main instance, a second instance with a short timeout covers the abort path.
`timescale 1ns/1ps
module tb_sysid_reader;

    localparam logic [31:0] TS_GOOD = 32'd1637742172;

    logic        clock;
    logic        reset;

    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;

    logic        t_start;
    logic        t_address;
    logic        t_read;
    logic        t_waitrequest;
    logic [31:0] t_readdata;
    logic        t_rdv;
    logic [31:0] t_id_value;
    logic [31:0] t_ts_value;
    logic        t_busy;
    logic        t_done;
    logic        t_id_ok;
    logic        t_ts_ok;
    logic        t_timeout;

    sysid_reader u_dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .id_value          (id_value),
        .ts_value          (ts_value),
        .busy              (busy),
        .done              (done),
        .id_ok             (id_ok),
        .ts_ok             (ts_ok),
        .timeout           (timeout)
    );

    sysid_reader #(.TIMEOUT_CYC(16'd8), .AUTO_START(1'b0)) u_dut_to (
        .clock             (clock),
        .reset             (reset),
        .start             (t_start),
        .avm_address       (t_address),
        .avm_read          (t_read),
        .avm_waitrequest   (t_waitrequest),
        .avm_readdata      (t_readdata),
        .avm_readdatavalid (t_rdv),
        .id_value          (t_id_value),
        .ts_value          (t_ts_value),
        .busy              (t_busy),
        .done              (t_done),
        .id_ok             (t_id_ok),
        .ts_ok             (t_ts_ok),
        .timeout           (t_timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Timeout instance: ID answers with zero latency, timestamp never answers.
    assign t_waitrequest = 1'b0;
    assign t_rdv         = t_read && !t_address;
    assign t_readdata    = 32'd0;

    // Slave model for the main instance.
    int          cfg_wait;
    int          cfg_lat;
    logic [31:0] mem_id;
    logic [31:0] mem_ts;
    logic        slv_clr;
    int          stall_cnt;
    int          lat_cnt;
    int          pend_lat;
    logic        pend;
    logic [31:0] pend_data;
    int          acc0;
    int          acc1;

    always_comb begin
        avm_waitrequest   = avm_read && (stall_cnt < cfg_wait);
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'd0;
        if (avm_read && !avm_waitrequest && cfg_lat == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = avm_address ? mem_ts : mem_id;
        end else if (pend && lat_cnt == pend_lat) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend_data;
        end
    end

    always_ff @(posedge clock) begin
        if (slv_clr) begin
            stall_cnt <= 0;
            lat_cnt   <= 0;
            pend_lat  <= 0;
            pend      <= 1'b0;
            pend_data <= 32'd0;
            acc0      <= 0;
            acc1      <= 0;
        end else begin
            if (!avm_read || !avm_waitrequest) stall_cnt <= 0;
            else                               stall_cnt <= stall_cnt + 1;
            if (pend && lat_cnt == pend_lat) pend <= 1'b0;
            else if (pend)                   lat_cnt <= lat_cnt + 1;
            if (avm_read && !avm_waitrequest) begin
                if (avm_address) acc1 <= acc1 + 1;
                else             acc0 <= acc0 + 1;
                if (cfg_lat > 0) begin
                    pend      <= 1'b1;
                    pend_lat  <= cfg_lat;
                    lat_cnt   <= 1;
                    pend_data <= avm_address ? mem_ts : mem_id;
                end
            end
        end
    end

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int cyc;
        cyc = 0;
        while (!done && cyc < budget) begin
            tick();
            cyc++;
        end
        check(name, done, 1);
    endtask

    typedef struct {
        logic [31:0] id_rd;
        logic [31:0] ts_rd;
        logic        exp_id_ok;
        logic        exp_ts_ok;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int s1;
        int n_stall;
        logic prev_stall;
        logic prev_addr;
        int cyc;

        vecs[0] = '{32'd0,         TS_GOOD,                 1'b1, 1'b1};
        vecs[1] = '{32'd0,         32'h1234_5678,           1'b1, 1'b0};
        vecs[2] = '{32'd1,         TS_GOOD,                 1'b0, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, TS_GOOD + 32'd1,         1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, TS_GOOD ^ 32'h8000_0000, 1'b0, 1'b0};
        vecs[5] = '{32'd0,         TS_GOOD,                 1'b1, 1'b1};

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        t_start  = 1'b0;
        slv_clr  = 1'b1;
        cfg_wait = 0;
        cfg_lat  = 2;
        mem_id   = 32'd0;
        mem_ts   = TS_GOOD;
        repeat (3) tick();

        check("rst_flags", {busy, done, id_ok, ts_ok, timeout, avm_read, avm_address}, 0);
        check("rst_id_value", id_value, 0);
        check("rst_ts_value", ts_value, 0);
        check("rst_to_flags", {t_busy, t_done, t_id_ok, t_ts_ok, t_timeout, t_read, t_address}, 0);

        // Auto-start after reset release; a start during busy must not add a check.
        slv_clr = 1'b0;
        s0 = acc0;
        s1 = acc1;
        reset = 1'b0;
        tick();
        check("auto_busy", busy, 1);
        check("auto_read_addr", {avm_read, avm_address}, 2'b10);
        check("to_no_autostart", t_busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("auto_done", 30);
        check("auto_oks", {id_ok, ts_ok, timeout}, 3'b110);
        repeat (10) tick();
        check("auto_still_done", {busy, done}, 2'b01);
        check("auto_acc_id", acc0 - s0, 1);
        check("auto_acc_ts", acc1 - s1, 1);

        // Zero-wait, zero-latency table: done lands exactly 3 cycles after start.
        cfg_lat = 0;
        for (int i = 0; i < 6; i++) begin
            mem_id = vecs[i].id_rd;
            mem_ts = vecs[i].ts_rd;
            start = 1'b1;
            tick();
            start = 1'b0;
            check($sformatf("vec%0d_done_cleared", i), done, 0);
            tick();
            check($sformatf("vec%0d_done_c2", i), done, 0);
            tick();
            check($sformatf("vec%0d_done_c3", i), done, 1);
            check($sformatf("vec%0d_id_value", i), id_value, vecs[i].id_rd);
            check($sformatf("vec%0d_ts_value", i), ts_value, vecs[i].ts_rd);
            check($sformatf("vec%0d_id_ok", i), id_ok, vecs[i].exp_id_ok);
            check($sformatf("vec%0d_ts_ok", i), ts_ok, vecs[i].exp_ts_ok);
            check($sformatf("vec%0d_timeout_busy", i), {timeout, busy}, 0);
        end

        // Stalling slave: 5 wait cycles per command, response 3 cycles after accept.
        mem_id   = 32'd0;
        mem_ts   = TS_GOOD;
        cfg_wait = 5;
        cfg_lat  = 3;
        s0 = acc0;
        s1 = acc1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_stall    = 0;
        prev_stall = 1'b0;
        prev_addr  = 1'b0;
        cyc        = 0;
        while (!done && cyc < 60) begin
            if (prev_stall) begin
                check("stall_read_hold", avm_read, 1);
                check("stall_addr_hold", avm_address, prev_addr);
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            if (prev_stall) n_stall++;
            tick();
            cyc++;
        end
        check("stall_done", done, 1);
        check("stall_cycles", n_stall, 10);
        check("stall_acc_id", acc0 - s0, 1);
        check("stall_acc_ts", acc1 - s1, 1);
        check("stall_oks", {id_ok, ts_ok, timeout}, 3'b110);

        // Timeout instance: TS never answers, abort 8 cycles after TS accept.
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        tick();
        check("to_ts_cmd", {t_read, t_address}, 2'b11);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) check("to_done_c7", t_done, 0);
            if (k == 8) check("to_done_c8", t_done, 1);
        end
        check("to_timeout", t_timeout, 1);
        check("to_oks", {t_id_ok, t_ts_ok}, 2'b10);
        check("to_read_busy", {t_read, t_busy}, 0);
        check("to_ts_value", t_ts_value, 0);
        check("to_id_value", t_id_value, 0);

        // Reset during ID_WAIT, stale response later lands during a stalled ID_CMD.
        mem_id   = 32'hBAD0_0001;
        cfg_wait = 0;
        cfg_lat  = 5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("r6_in_id_wait", {busy, avm_read, avm_address}, 3'b100);
        #3;
        reset = 1'b1;
        #1;
        check("r6_async_flags", {busy, done, id_ok, ts_ok, timeout, avm_read, avm_address}, 0);
        check("r6_async_values", {id_value, ts_value} == 64'd0, 1);
        mem_id   = 32'd0;
        cfg_lat  = 0;
        cfg_wait = 6;
        @(posedge clock);
        #1;
        s0 = acc0;
        s1 = acc1;
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r6_rerun_busy", busy, 1);
        repeat (3) tick();
        check("r6_stale_ignored", {id_value, 1'b0, busy, avm_address}, {32'd0, 1'b0, 1'b1, 1'b0});
        wait_done("r6_done", 40);
        check("r6_oks", {id_ok, ts_ok, timeout}, 3'b110);
        check("r6_id_value", id_value, 0);
        check("r6_ts_value", ts_value, TS_GOOD);
        repeat (5) tick();
        check("r6_acc_id", acc0 - s0, 1);
        check("r6_acc_ts", acc1 - s1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
